// File: rtl/us_pkg.sv
// Shared definitions for the ultrasonic obstacle filter: widths, default
// thresholds, FSM state encoding and the input clamp helper.
package us_pkg;

  localparam int MM_W        = 16;
  localparam int NEAR_MM_DEF = 70;
  localparam int FAR_MM_DEF  = 90;
  localparam int MAX_MM_DEF  = 4000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    ACCUM   = 2'd2,
    PUBLISH = 2'd3
  } us_state_t;

  function automatic logic [MM_W-1:0] clamp_mm(input logic [MM_W-1:0] d,
                                               input logic [MM_W-1:0] max_mm);
    return (d > max_mm) ? max_mm : d;
  endfunction

endpackage

// File: rtl/us_sample_ring.sv
// Circular buffer of the last 2**DEPTH_LOG2 samples with a running sum.
// The sum is adjusted incrementally: add the new sample, drop the evicted one.
module us_sample_ring
  import us_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                       clk_50M,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [MM_W-1:0]            din,
  output logic [MM_W+DEPTH_LOG2-1:0] sum,
  output logic                       full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = MM_W + DEPTH_LOG2;

  logic [MM_W-1:0]       buf_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2:0]   fill;
  logic [MM_W-1:0]       evicted;

  assign full = (fill == (DEPTH_LOG2 + 1)'(DEPTH));
  // Until the window has wrapped once the slot being written holds no sample.
  assign evicted = full ? buf_q[wptr] : '0;

  always_ff @(posedge clk_50M) begin
    if (!reset || clear) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum  <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (push) begin
      buf_q[wptr] <= din;
      sum         <= sum + SUM_W'(din) - SUM_W'(evicted);
      wptr        <= wptr + DEPTH_LOG2'(1);
      if (!full) fill <= fill + (DEPTH_LOG2 + 1)'(1);
    end
  end

endmodule

// File: rtl/us_obstacle_filter.sv
// Samples the HC-SR04 distance once per period, averages a sliding window and
// produces a hysteresis-qualified wall_near flag.
module us_obstacle_filter
  import us_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 600_000,
  parameter int DEPTH_LOG2    = 2,
  parameter int NEAR_MM       = NEAR_MM_DEF,
  parameter int FAR_MM        = FAR_MM_DEF,
  parameter int MAX_MM        = MAX_MM_DEF
) (
  input  logic            clk_50M,
  input  logic            reset,
  input  logic            enable,
  input  logic [MM_W-1:0] distance_in,
  output logic [MM_W-1:0] dist_avg,
  output logic            avg_valid,
  output logic            wall_near,
  output logic            window_full
);

  localparam int              TMR_W    = $clog2(SAMPLE_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam int              SUM_W    = MM_W + DEPTH_LOG2;

  us_state_t         state, state_next;
  logic [TMR_W-1:0]  timer;
  logic              strike;
  logic [MM_W-1:0]   sample_q;
  logic              ring_push;
  logic              ring_full;
  logic              do_publish;
  logic [SUM_W-1:0]  ring_sum;
  logic [MM_W-1:0]   new_avg;
  logic              new_near;

  assign strike = enable && (timer == TMR_LAST);

  always_ff @(posedge clk_50M) begin
    if (!reset || !enable || timer == TMR_LAST) timer <= '0;
    else                                         timer <= timer + TMR_W'(1);
  end

  always_ff @(posedge clk_50M) begin
    if (!reset)                        sample_q <= '0;
    else if (strike && state == COUNT) sample_q <= clamp_mm(distance_in, MM_W'(MAX_MM));
  end

  // FSM: state register
  always_ff @(posedge clk_50M) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state; dropping enable wins over any strike or publish
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = COUNT;
        COUNT:   if (strike) state_next = ACCUM;
        ACCUM:   state_next = PUBLISH;
        PUBLISH: state_next = COUNT;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    ring_push  = 1'b0;
    do_publish = 1'b0;
    if (enable) begin
      ring_push  = (state == ACCUM);
      do_publish = (state == PUBLISH) && ring_full;
    end
  end

  us_sample_ring #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ring (
    .clk_50M(clk_50M),
    .reset  (reset),
    .clear  (!enable),
    .push   (ring_push),
    .din    (sample_q),
    .sum    (ring_sum),
    .full   (ring_full)
  );

  assign new_avg = ring_sum[SUM_W-1:DEPTH_LOG2];

  always_comb begin
    new_near = wall_near;
    if (new_avg <= MM_W'(NEAR_MM))     new_near = 1'b1;
    else if (new_avg >= MM_W'(FAR_MM)) new_near = 1'b0;
  end

  // dist_avg and wall_near survive a disable so the solver keeps its last view.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      dist_avg    <= '0;
      avg_valid   <= 1'b0;
      wall_near   <= 1'b0;
      window_full <= 1'b0;
    end else if (!enable) begin
      avg_valid   <= 1'b0;
      window_full <= 1'b0;
    end else begin
      avg_valid <= do_publish;
      if (do_publish) begin
        dist_avg    <= new_avg;
        wall_near   <= new_near;
        window_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_us_obstacle_filter.sv
// Self-checking bench for us_obstacle_filter: directed scenarios with literal
// expectations plus a randomized run against a window-average reference model.
module tb_us_obstacle_filter;

  localparam int SP    = 10;
  localparam int DEPTH = 4;

  logic        clk_50M;
  logic        reset;
  logic        enable;
  logic [15:0] distance_in;
  logic [15:0] dist_avg;
  logic        avg_valid;
  logic        wall_near;
  logic        window_full;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  us_obstacle_filter #(
    .SAMPLE_PERIOD(SP)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .enable     (enable),
    .distance_in(distance_in),
    .dist_avg   (dist_avg),
    .avg_valid  (avg_valid),
    .wall_near  (wall_near),
    .window_full(window_full)
  );

  // Clock and watchdog
  initial begin
    clk_50M = 1'b0;
    forever #5 clk_50M = ~clk_50M;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a queue holding the last DEPTH accepted samples. A sample
  // taken at the strike edge becomes visible two edges later if enable and
  // reset survive that long.
  logic [15:0] win_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_avg   = '0;
  bit          m_valid = 0;
  bit          m_near  = 0;
  bit          m_full  = 0;
  int          en_cycles = 0;
  int          edge_n    = 0;
  bit          pend      = 0;
  int          pend_due  = 0;
  logic [15:0] pend_val  = '0;

  always @(posedge clk_50M) begin
    int unsigned s;
    m_valid = 0;
    if (!reset) begin
      m_avg = '0; m_near = 0; m_full = 0;
      win_q.delete(); en_cycles = 0; pend = 0;
    end else if (!enable) begin
      m_full = 0;
      win_q.delete(); en_cycles = 0; pend = 0;
    end else begin
      if (pend && edge_n == pend_due) begin
        pend = 0;
        win_q.push_back(pend_val);
        if (win_q.size() > DEPTH) void'(win_q.pop_front());
        if (win_q.size() == DEPTH) begin
          s = 0;
          foreach (win_q[i]) s += win_q[i];
          m_avg   = 16'(s / DEPTH);
          m_valid = 1;
          m_full  = 1;
          if (m_avg <= 70)      m_near = 1;
          else if (m_avg >= 90) m_near = 0;
          exp_q.push_back(m_avg);
        end
      end
      // One strike every SP enabled cycles, the first on the SP-th.
      if (en_cycles % SP == SP - 1) begin
        pend     = 1;
        pend_due = edge_n + 2;
        pend_val = (distance_in > 16'd4000) ? 16'd4000 : distance_in;
      end
      en_cycles++;
    end
    edge_n++;
  end

  // Scoreboard: compare every cycle, and pop the expected average per pulse.
  always @(negedge clk_50M) begin
    logic [15:0] e;
    if (chk_on) begin
      check("avg_valid", avg_valid, m_valid);
      check("dist_avg", dist_avg, m_avg);
      check("wall_near", wall_near, m_near);
      check("window_full", window_full, m_full);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got empty expected entry");
        end else begin
          e = exp_q.pop_front();
          check("sb_avg", dist_avg, e);
        end
      end
    end
  end

  // Driver helpers
  task automatic wait_pulse(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk_50M);
      n++;
    end while (!avg_valid && n < 60);
    if (!avg_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no pulse in %0d cycles expected pulse", name, n);
    end
  endtask

  task automatic feed(input logic [15:0] d, input int samples);
    int n;
    distance_in = d;
    for (int i = 0; i < samples; i++) wait_pulse("feed", n);
  endtask

  function automatic logic [15:0] pick_dist();
    case ($urandom_range(0, 9))
      0:       return 16'd0;
      1:       return 16'($urandom_range(4001, 65535));
      2:       return 16'($urandom_range(0, 4000));
      default: return 16'($urandom_range(40, 120));
    endcase
  endfunction

  initial begin
    int n;
    int pulses;
    int dis_left;
    reset = 1'b0; enable = 1'b0; distance_in = '0;

    // 1: reset, then idle with enable low
    @(negedge clk_50M);
    chk_on = 1;
    repeat (4) @(negedge clk_50M);
    reset = 1'b1;
    pulses = 0;
    repeat (100) begin
      @(negedge clk_50M);
      if (avg_valid) pulses++;
    end
    check("idle_pulses", pulses, 0);
    check("idle_avg", dist_avg, 0);
    check("idle_near", wall_near, 0);
    check("idle_full", window_full, 0);

    // 2: constant 100, first pulse two cycles after the 4th strike
    distance_in = 16'd100;
    enable = 1'b1;
    wait_pulse("first", n);
    check("first_latency", n, 42);
    check("first_avg", dist_avg, 100);
    check("first_near", wall_near, 0);
    check("first_full", window_full, 1);
    wait_pulse("second", n);
    check("second_period", n, 10);

    // 3: hysteresis walk
    feed(16'd60, 4);
    check("h60_avg", dist_avg, 60);
    check("h60_near", wall_near, 1);
    distance_in = 16'd80;
    for (int i = 0; i < 4; i++) begin
      wait_pulse("h80", n);
      check("h80_avg", dist_avg, 32'(65 + 5 * i));
      check("h80_near", wall_near, 1);
    end
    feed(16'd100, 1);
    check("h85_avg", dist_avg, 85);
    check("h85_near", wall_near, 1);
    feed(16'd100, 1);
    check("h90_avg", dist_avg, 90);
    check("h90_near", wall_near, 0);

    // 4: clamp of an oversize echo
    feed(16'd65535, 1);
    check("clamp_first_avg", dist_avg, 1070);
    feed(16'd100, 3);
    check("clamp_avg", dist_avg, 1075);

    // 5: disable after two samples, then re-enable
    feed(16'd50, 2);
    check("pre_dis_avg", dist_avg, 75);
    enable = 1'b0;
    repeat (3) @(negedge clk_50M);
    check("dis_avg_hold", dist_avg, 75);
    check("dis_near_hold", wall_near, 0);
    check("dis_full", window_full, 0);
    enable = 1'b1;
    wait_pulse("reen", n);
    check("reen_latency", n, 42);
    check("reen_avg", dist_avg, 50);
    check("reen_near", wall_near, 1);

    // 6: reset during the PUBLISH cycle of the next sample
    repeat (9) @(negedge clk_50M);
    reset = 1'b0;
    @(negedge clk_50M);
    check("rst_pub_valid", avg_valid, 0);
    check("rst_pub_avg", dist_avg, 0);
    check("rst_pub_near", wall_near, 0);
    check("rst_pub_full", window_full, 0);
    reset = 1'b1;

    // Randomized run against the model
    dis_left = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_50M);
      reset = 1'b1;
      if ($urandom_range(0, 2) == 0) distance_in = pick_dist();
      if (dis_left > 0) begin
        dis_left--;
        if (dis_left == 0) enable = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        enable   = 1'b0;
        dis_left = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 999) == 0) reset = 1'b0;
    end
    reset = 1'b1; enable = 1'b1;
    repeat (3) @(negedge clk_50M);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
